// File: rtl/ts_pkg.sv
// Shared constants and state type for MPEG-2 TS sync acquisition.
package ts_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h47;
  localparam int         PKT_LEN_188 = 188;
  localparam int         PKT_LEN_204 = 204;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/ts_sync_lock_if.sv
// Byte-stream bundle between a TS source, the sync-lock block and its consumer.
interface ts_sync_lock_if #(
  parameter int ERRW = 16
);
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            err_clr;
  logic [7:0]      byte_out;
  logic            out_valid;
  logic            sop;
  logic            eop;
  logic            locked;
  logic            lock_lost;
  logic [ERRW-1:0] sync_err_cnt;

  modport master (
    output byte_in, byte_valid, err_clr,
    input  byte_out, out_valid, sop, eop, locked, lock_lost, sync_err_cnt
  );

  modport slave (
    input  byte_in, byte_valid, err_clr,
    output byte_out, out_valid, sop, eop, locked, lock_lost, sync_err_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ts_sync_lock.sv
// TS sync hunt/verify/lock FSM with flywheel; forwards aligned packets with sop/eop.
module ts_sync_lock #(
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         LOCK_CNT   = 5,
  parameter int         UNLOCK_CNT = 3,
  parameter int         ERRW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  ts_sync_lock_if.slave  bus
);
  import ts_pkg::*;

  localparam int POSW = $clog2(PKT_LEN);
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int MW   = $clog2(UNLOCK_CNT + 1);
  localparam logic [POSW-1:0] POS_LAST  = POSW'(PKT_LEN - 1);
  localparam logic [GW-1:0]   GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0]   MISS_LAST = MW'(UNLOCK_CNT - 1);

  sync_state_t     state_q, state_d;
  logic [POSW-1:0] pos_q, pos_d, pos_inc;
  logic [GW-1:0]   good_q, good_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic            out_valid_q, out_valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            locked_q, locked_d;
  logic            lock_lost_q, lock_lost_d;
  logic            err_inc;
  logic            is_sync;

  assign is_sync = (bus.byte_in == SYNC_BYTE);
  assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    byte_out_d  = bus.byte_valid ? bus.byte_in : byte_out_q;
    out_valid_d = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    lock_lost_d = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      SEARCH: begin
        if (bus.byte_valid && is_sync) begin
          state_d = VERIFY;
          pos_d   = POSW'(1);
          good_d  = GW'(1);
        end
      end

      VERIFY: begin
        if (bus.byte_valid) begin
          pos_d = pos_inc;
          if (pos_q == '0) begin
            if (!is_sync) begin
              // A failed candidate cannot itself be a sync byte, so restart cleanly.
              state_d = SEARCH;
              pos_d   = '0;
              good_d  = '0;
            end else if (good_q == GOOD_LAST) begin
              state_d     = LOCKED;
              good_d      = '0;
              miss_d      = '0;
              out_valid_d = 1'b1;
              sop_d       = 1'b1;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
      end

      LOCKED: begin
        if (bus.byte_valid) begin
          pos_d       = pos_inc;
          out_valid_d = 1'b1;
          sop_d       = (pos_q == '0);
          eop_d       = (pos_q == POS_LAST);
          if (pos_q == '0) begin
            if (is_sync) begin
              miss_d = '0;
            end else begin
              err_inc = 1'b1;
              if (miss_q == MISS_LAST) begin
                // Lock drops here; the bad sync is swallowed rather than forwarded.
                state_d     = SEARCH;
                pos_d       = '0;
                miss_d      = '0;
                lock_lost_d = 1'b1;
                out_valid_d = 1'b0;
                sop_d       = 1'b0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = SEARCH;
        pos_d   = '0;
        good_d  = '0;
        miss_d  = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  // NOTE: synchronous reset clears every flop, so no eop can leak out after a mid-packet reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SEARCH;
      pos_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      byte_out_q  <= '0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      byte_out_q  <= byte_out_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  sat_counter #(.W(ERRW)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (bus.err_clr),
    .cnt (bus.sync_err_cnt)
  );

  assign bus.byte_out  = byte_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sop       = sop_q;
  assign bus.eop       = eop_q;
  assign bus.locked    = locked_q;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_ts_sync_lock.sv
// Self-checking bench: two ts_sync_lock configurations against a packet-phase reference model.
module tb_ts_sync_lock;
  import ts_pkg::*;

  localparam int P0 = PKT_LEN_188, L0 = 5, U0 = 3;
  localparam int P1 = PKT_LEN_204, L1 = 2, U1 = 1;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  ts_sync_lock_if #(.ERRW(16)) bus0 ();
  ts_sync_lock_if #(.ERRW(16)) bus1 ();

  ts_sync_lock #(.PKT_LEN(P0), .SYNC_BYTE(SYNC_BYTE), .LOCK_CNT(L0), .UNLOCK_CNT(U0), .ERRW(16))
    dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  ts_sync_lock #(.PKT_LEN(P1), .SYNC_BYTE(SYNC_BYTE), .LOCK_CNT(L1), .UNLOCK_CNT(U1), .ERRW(16))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0=hunting, 1=confirming, 2=locked; phase is kept as the
  // valid-byte index of the first sync (anchor), positions derive from modulo arithmetic.
  typedef struct {
    int         mode;
    int         anchor;
    int         n;
    int         misses;
    logic [7:0] bo;
    logic       ov, sop, eop, lk, ll;
    logic [15:0] err;
  } model_t;

  model_t m [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rnd_data();
    logic [7:0] r;
    r = 8'($urandom);
    if (r == SYNC_BYTE) r = 8'h48;
    return r;
  endfunction

  task automatic model_step(input int i, input logic [7:0] b, input logic v,
                            input logic clr, input logic rstn);
    int p, l, u, k;
    p = (i == 0) ? P0 : P1;
    l = (i == 0) ? L0 : L1;
    u = (i == 0) ? U0 : U1;
    if (!rstn) begin
      m[i].mode = 0; m[i].anchor = 0; m[i].n = 0; m[i].misses = 0;
      m[i].bo = '0; m[i].ov = 0; m[i].sop = 0; m[i].eop = 0;
      m[i].lk = 0; m[i].ll = 0; m[i].err = '0;
      return;
    end
    m[i].ov = 0; m[i].sop = 0; m[i].eop = 0; m[i].ll = 0;
    if (v) begin
      m[i].bo = b;
      k = m[i].n - m[i].anchor;
      if (m[i].mode == 0) begin
        if (b == SYNC_BYTE) begin
          m[i].mode = 1;
          m[i].anchor = m[i].n;
        end
      end else if (m[i].mode == 1) begin
        if (k % p == 0) begin
          if (b != SYNC_BYTE) m[i].mode = 0;
          else if (k / p + 1 == l) begin
            m[i].mode = 2; m[i].misses = 0; m[i].ov = 1; m[i].sop = 1;
          end
        end
      end else begin
        k = k % p;
        m[i].ov = 1;
        m[i].sop = (k == 0);
        m[i].eop = (k == p - 1);
        if (k == 0) begin
          if (b == SYNC_BYTE) m[i].misses = 0;
          else begin
            if (m[i].err != 16'hFFFF) m[i].err = m[i].err + 16'd1;
            m[i].misses++;
            if (m[i].misses == u) begin
              m[i].mode = 0; m[i].ll = 1; m[i].ov = 0; m[i].sop = 0;
            end
          end
        end
      end
      m[i].n++;
    end
    if (clr) m[i].err = '0;
    m[i].lk = (m[i].mode == 2);
  endtask

  function automatic logic [28:0] obs_of(input int sel);
    if (sel == 0)
      return {bus0.byte_out, bus0.out_valid, bus0.sop, bus0.eop, bus0.locked, bus0.lock_lost, bus0.sync_err_cnt};
    return {bus1.byte_out, bus1.out_valid, bus1.sop, bus1.eop, bus1.locked, bus1.lock_lost, bus1.sync_err_cnt};
  endfunction

  function automatic logic [28:0] exp_of(input int sel);
    return {m[sel].bo, m[sel].ov, m[sel].sop, m[sel].eop, m[sel].lk, m[sel].ll, m[sel].err};
  endfunction

  // One clock: drive the selected DUT, hold the other idle, compare after the edge.
  task automatic tick(input int sel, input logic [7:0] b, input logic v,
                      input logic clr, input logic rstn);
    bus0.byte_in = (sel == 0) ? b : 8'h00;
    bus0.byte_valid = (sel == 0) ? v : 1'b0;
    bus0.err_clr = (sel == 0) ? clr : 1'b0;
    rst0 = (sel == 0) ? rstn : 1'b1;
    bus1.byte_in = (sel == 1) ? b : 8'h00;
    bus1.byte_valid = (sel == 1) ? v : 1'b0;
    bus1.err_clr = (sel == 1) ? clr : 1'b0;
    rst1 = (sel == 1) ? rstn : 1'b1;
    @(posedge clk);
    model_step(0, bus0.byte_in, bus0.byte_valid, bus0.err_clr, rst0);
    model_step(1, bus1.byte_in, bus1.byte_valid, bus1.err_clr, rst1);
    @(negedge clk);
    check((sel == 0) ? "cycle_dut0" : "cycle_dut1", 64'(obs_of(sel)), 64'(exp_of(sel)));
  endtask

  initial begin
    int first_lock, first_eop, early_ov, idle_ov, ll_cnt, vi;
    logic [7:0] b;
    logic v, clr;

    rst0 = 1'b0; rst1 = 1'b0;
    bus0.byte_in = '0; bus0.byte_valid = 0; bus0.err_clr = 0;
    bus1.byte_in = '0; bus1.byte_valid = 0; bus1.err_clr = 0;
    @(negedge clk);
    tick(0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_dut0", 64'(obs_of(0)), 64'd0);
    check("reset_dut1", 64'(obs_of(1)), 64'd0);

    // Six clean packets from index 0.
    first_lock = -1; first_eop = -1; early_ov = 0;
    for (int i = 0; i < 6 * 188; i++) begin
      b = (i % 188 == 0) ? SYNC_BYTE : rnd_data();
      tick(0, b, 1'b1, 1'b0, 1'b1);
      if (bus0.locked && first_lock < 0) first_lock = i;
      if (bus0.eop && first_eop < 0) first_eop = i;
      if (bus0.out_valid && i < 752) early_ov++;
      if (i == 752) check("lock_sop_byte", {bus0.sop, bus0.out_valid, bus0.byte_out}, {1'b1, 1'b1, SYNC_BYTE});
    end
    check("first_lock_idx", 64'(first_lock), 64'(752));
    check("first_eop_idx", 64'(first_eop), 64'(939));
    check("no_out_before_lock", 64'(early_ov), 64'd0);

    // Flywheel miss at 1128, clear at 1400, then three misses in a row.
    ll_cnt = 0;
    for (int i = 1128; i < 1900; i++) begin
      if (i % 188 == 0) b = (i == 1128 || i == 1504 || i == 1692 || i == 1880) ? 8'h00 : SYNC_BYTE;
      else b = rnd_data();
      tick(0, b, 1'b1, (i == 1400), 1'b1);
      if (bus0.lock_lost) ll_cnt++;
      if (i == 1128) check("flywheel_fwd", {bus0.out_valid, bus0.sop, bus0.locked, bus0.byte_out, bus0.sync_err_cnt},
                           {1'b1, 1'b1, 1'b1, 8'h00, 16'd1});
      if (i == 1692) check("two_misses_locked", 64'(bus0.locked), 64'd1);
      if (i == 1880) check("third_miss_drop", {bus0.lock_lost, bus0.locked, bus0.out_valid, bus0.sync_err_cnt},
                           {1'b1, 1'b0, 1'b0, 16'd3});
    end
    check("lock_lost_once", 64'(ll_cnt), 64'd1);

    // Stray sync at 5, real phase at 100: the stray verify fails at 193, hunting resumes at 288.
    tick(0, 8'h00, 1'b0, 1'b0, 1'b0);
    first_lock = -1;
    for (int i = 0; i < 1100; i++) begin
      if (i == 5 || (i >= 100 && (i - 100) % 188 == 0)) b = SYNC_BYTE;
      else b = rnd_data();
      tick(0, b, 1'b1, 1'b0, 1'b1);
      if (i == 194) check("stray_verify_fail", 64'(bus0.locked), 64'd0);
      if (bus0.locked && first_lock < 0) first_lock = i;
    end
    check("realign_lock_idx", 64'(first_lock), 64'(288 + 4 * 188));
    check("realign_phase", 64'((first_lock - 100) % 188), 64'd0);

    // byte_valid toggling every cycle; positions counted in valid bytes.
    tick(0, 8'h00, 1'b0, 1'b0, 1'b0);
    first_lock = -1; first_eop = -1; idle_ov = 0; vi = 0;
    for (int c = 0; c < 1920; c++) begin
      v = (c % 2 == 0);
      if (vi % 188 == 0) b = (vi == 940) ? 8'h11 : SYNC_BYTE;
      else b = rnd_data();
      tick(0, b, v, 1'b0, 1'b1);
      if (v) begin
        if (bus0.locked && first_lock < 0) first_lock = vi;
        if (bus0.eop && first_eop < 0) first_eop = vi;
        vi++;
      end else if (bus0.out_valid || bus0.sop || bus0.eop) idle_ov++;
    end
    check("toggle_lock_idx", 64'(first_lock), 64'(752));
    check("toggle_eop_idx", 64'(first_eop), 64'(939));
    check("toggle_idle_quiet", 64'(idle_ov), 64'd0);

    // Miss coinciding with err_clr, then a mid-packet reset.
    for (int i = 960; i < 1150; i++) begin
      b = (i % 188 == 0) ? ((i == 1128) ? 8'h00 : SYNC_BYTE) : rnd_data();
      tick(0, b, 1'b1, (i == 1128), 1'b1);
      if (i == 1128) check("clr_beats_inc", {bus0.locked, bus0.sop, bus0.sync_err_cnt}, {1'b1, 1'b1, 16'd0});
    end
    tick(0, rnd_data(), 1'b1, 1'b0, 1'b0);
    check("midpkt_reset", 64'(obs_of(0)), 64'd0);

    // RS-coded configuration: lock at 204, single miss drops lock.
    tick(1, 8'h00, 1'b0, 1'b0, 1'b0);
    first_lock = -1;
    for (int i = 0; i <= 612; i++) begin
      b = (i % 204 == 0) ? ((i == 612) ? 8'h00 : SYNC_BYTE) : rnd_data();
      tick(1, b, 1'b1, 1'b0, 1'b1);
      if (bus1.locked && first_lock < 0) first_lock = i;
      if (i == 612) check("rs_single_miss", {bus1.lock_lost, bus1.locked, bus1.out_valid, bus1.sync_err_cnt},
                          {1'b1, 1'b0, 1'b0, 16'd1});
    end
    check("rs_lock_idx", 64'(first_lock), 64'(204));

    // Randomized traffic: random gaps, random data (stray syncs included), corrupted syncs, clears.
    for (int s = 0; s < 2; s++) begin
      int plen;
      plen = (s == 0) ? P0 : P1;
      tick(s, 8'h00, 1'b0, 1'b0, 1'b0);
      vi = int'($urandom % plen);
      for (int c = 0; c < 4000; c++) begin
        v = ($urandom % 4 != 0);
        if (vi % plen == 0) b = ($urandom % 6 == 0) ? rnd_data() : SYNC_BYTE;
        else b = 8'($urandom);
        clr = ($urandom % 64 == 0);
        tick(s, b, v, clr, 1'b1);
        if (v) vi++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
